// File: rtl/fetch_aligner.sv
// fetch_aligner: word-aligned instruction fetch with a 4-halfword queue delivering RV32IC raw instructions and their PCs
module fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_raw,
   output logic [31:0] inst_pc
);
   typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;
   state_t state, state_n;
   logic [63:0] q, q_n, kept;
   logic [2:0] count, count_n, cnt_pop;
   logic [31:0] head_pc, fetch_addr, push_data;
   logic skip_low, head_long, complete, accept, push, issue;
   logic [1:0] len, pop_n;
   assign head_long = q[1:0] == 2'b11;
   assign complete = head_long ? count >= 3'd2 : count >= 3'd1;
   assign inst_valid = complete && !redirect;
   assign inst_raw = head_long ? q[31:0] : {16'h0, q[15:0]};
   assign inst_pc = head_pc;
   assign accept = inst_valid && inst_ready;
   assign len = head_long ? 2'd2 : 2'd1;
   assign pop_n = accept ? len : 2'd0;
   assign push = state == BUSY && imem_rvalid && !redirect;
   assign issue = state == IDLE && count <= 3'd2 && !redirect;
   assign cnt_pop = count - {1'b0, pop_n};
   assign push_data = skip_low ? {16'h0, imem_rdata[31:16]} : imem_rdata;
   // slots above the live count may hold stale halfwords, so mask before appending
   always_comb begin
      kept = (q >> {pop_n, 4'b0000}) & ~({64{1'b1}} << {cnt_pop, 4'b0000});
      q_n = push ? kept | ({32'h0, push_data} << {cnt_pop, 4'b0000}) : kept;
      count_n = cnt_pop + (push ? (skip_low ? 3'd1 : 3'd2) : 3'd0);
      state_n = state == IDLE ? (issue ? BUSY : IDLE) :
                imem_rvalid ? IDLE :
                (state == BUSY && !redirect) ? BUSY : DISCARD;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= 3'd0;
         q <= '0;
         head_pc <= RESET_PC & ~32'h1;
         fetch_addr <= RESET_PC & ~32'h3;
         skip_low <= RESET_PC[1];
         imem_req <= 1'b0;
         imem_addr <= 32'h0;
      end else begin
         state <= state_n;
         imem_req <= issue;
         if (issue) begin
            imem_addr <= fetch_addr;
            fetch_addr <= fetch_addr + 32'd4;
         end
         if (redirect) begin
            count <= 3'd0;
            head_pc <= redirect_pc & ~32'h1;
            fetch_addr <= redirect_pc & ~32'h3;
            skip_low <= redirect_pc[1];
         end else begin
            q <= q_n;
            count <= count_n;
            if (accept) head_pc <= head_pc + {29'd0, len, 1'b0};
            if (push) skip_low <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: scoreboard bench with a latency-programmable memory model for fetch_aligner
module tb_fetch_aligner;
   logic clk = 0, rst = 1, redirect = 0;
   logic [31:0] redirect_pc = 0;
   logic imem_req, inst_valid;
   logic [31:0] imem_addr, inst_raw, inst_pc;
   logic imem_rvalid = 0, inst_ready = 0, hold = 0;
   logic [31:0] imem_rdata = 0;
   typedef struct {logic [31:0] pc; logic [31:0] raw;} exp_t;
   exp_t sb[$];
   logic [31:0] req_log[$];
   logic [31:0] mem [0:255];
   logic [31:0] pend = 0, resp_addr = 0;
   int checks = 0, errors = 0, lat = 1, cd = 0;

   fetch_aligner #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_raw(inst_raw), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] hw(input logic [31:0] p);
      return {p[13:0], 2'b01};
   endfunction

   function automatic logic [31:0] cexp(input logic [31:0] p);
      return {16'h0, hw(p)};
   endfunction

   // memory: one outstanding request, response lat cycles after the request is visible
   initial forever begin
      @(posedge clk); #1;
      imem_rvalid = 0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            imem_rvalid = 1;
            imem_rdata = mem[pend[9:2]];
            resp_addr = pend;
         end
      end
      if (imem_req) begin
         pend = imem_addr;
         cd = lat;
         req_log.push_back(imem_addr);
      end
   end

   // consumer: ready only while an expected instruction is queued
   initial forever begin
      @(negedge clk);
      inst_ready = sb.size() > 0 && !hold;
      if (inst_valid && inst_ready) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (inst_pc !== e.pc || inst_raw !== e.raw) begin
            errors++;
            $display("FAIL deliver: got pc=%h raw=%h, expected pc=%h raw=%h", inst_pc, inst_raw, e.pc, e.raw);
         end
      end
   end

   task automatic expect_inst(input logic [31:0] pc, input logic [31:0] raw);
      sb.push_back('{pc: pc, raw: raw});
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d instructions never delivered, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      @(posedge clk); #1;
      redirect = 1;
      redirect_pc = pc;
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_valid: inst_valid=%b during redirect, required 0", inst_valid);
      end
      req_log.delete();
      @(posedge clk); #1;
      redirect = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, required 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h, required 0", imem_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", inst_valid); end
      checks++; if (inst_raw !== 32'h0) begin errors++; $display("FAIL rst_raw: got %h, required 0", inst_raw); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h, required 0", inst_pc); end
      req_log.delete();
      expect_inst(32'h0, 32'h0000_0013);
      expect_inst(32'h4, 32'h00a0_0093);
      @(posedge clk); #1;
      rst = 0;
      wait_drain("reset_stream");
      checks++;
      if (req_log.size() < 2 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4) begin
         errors++;
         $display("FAIL reset_addrs: got %0d reqs first %h second %h, required 0 then 4", req_log.size(), req_log[0], req_log[1]);
      end
   endtask

   task automatic test_compressed;
      int n;
      lat = 1;
      do_redirect(32'h20);
      expect_inst(32'h20, 32'h0000_0001);
      expect_inst(32'h22, 32'h0000_4505);
      wait_drain("compressed");
      n = 0;
      foreach (req_log[i]) if (req_log[i] == 32'h20) n++;
      checks++;
      if (n != 1 || req_log[0] !== 32'h20) begin
         errors++;
         $display("FAIL compressed_fetches: got %0d fetches of 0x20 (first %h), required 1", n, req_log[0]);
      end
   endtask

   task automatic test_straddle;
      logic seen;
      seen = 0;
      lat = 3;
      do_redirect(32'h40);
      expect_inst(32'h40, 32'h0000_0001);
      expect_inst(32'h42, 32'h0050_0513);
      expect_inst(32'h46, 32'h0000_1234);
      for (int i = 0; i < 200 && sb.size() > 0; i++) begin
         @(negedge clk); #1;
         if (!seen && inst_pc == 32'h42) begin
            checks++;
            if (inst_valid !== 1'b0) begin
               errors++;
               $display("FAIL straddle_early: inst_valid=%b before second half arrived, required 0", inst_valid);
            end
         end
         if (imem_rvalid && resp_addr == 32'h44) seen = 1;
      end
      wait_drain("straddle");
   endtask

   task automatic test_redirect_stale;
      logic found;
      found = 0;
      lat = 3;
      do_redirect(32'h8);
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 32'h8) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL stale_setup: fetch of 0x8 never issued, required within 30 cycles");
      end
      do_redirect(32'h102);
      expect_inst(32'h102, 32'h0000_0001);
      expect_inst(32'h104, 32'h0000_4505);
      expect_inst(32'h106, 32'h0000_0000);
      wait_drain("redirect_stale");
      checks++;
      if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
         errors++;
         $display("FAIL stale_addr: first fetch after redirect %h (%0d reqs), required 00000100", req_log[0], req_log.size());
      end
   endtask

   task automatic test_backpressure;
      lat = 1;
      do_redirect(32'h180);
      for (int i = 0; i < 4; i++) expect_inst(32'h180 + 2 * i, cexp(32'h180 + 2 * i));
      wait_drain("bp_pre");
      hold = 1;
      for (int i = 4; i < 12; i++) expect_inst(32'h180 + 2 * i, cexp(32'h180 + 2 * i));
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); #1;
         if (c >= 6) begin
            checks++;
            if (imem_req !== 1'b0) begin
               errors++;
               $display("FAIL bp_req: imem_req=%b at hold cycle %0d, required 0", imem_req, c);
            end
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h188 || inst_raw !== cexp(32'h188)) begin
               errors++;
               $display("FAIL bp_hold: valid=%b pc=%h raw=%h at cycle %0d, required 1 00000188 %h", inst_valid, inst_pc, inst_raw, c, cexp(32'h188));
            end
         end
      end
      hold = 0;
      wait_drain("bp_release");
   endtask

   task automatic test_redirect_rvalid_reset;
      logic found;
      found = 0;
      lat = 1;
      do_redirect(32'h1c0);
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (imem_req) found = 1;
      end
      @(posedge clk); #1;
      redirect = 1;
      redirect_pc = 32'h200;
      @(negedge clk);
      checks++;
      if (!found || imem_rvalid !== 1'b1 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL rv_redirect: req_seen=%b rvalid=%b inst_valid=%b, required 1 1 0", found, imem_rvalid, inst_valid);
      end
      req_log.delete();
      @(posedge clk); #1;
      redirect = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         errors++;
         $display("FAIL rv_refetch: req=%b addr=%h, required 1 00000200", imem_req, imem_addr);
      end
      #1 rst = 1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_req: got %b, required 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL async_addr: got %h, required 0", imem_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b, required 0", inst_valid); end
      checks++; if (inst_raw !== 32'h0) begin errors++; $display("FAIL async_raw: got %h, required 0", inst_raw); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL async_pc: got %h, required 0", inst_pc); end
      expect_inst(32'h0, 32'h0000_0013);
      expect_inst(32'h4, 32'h00a0_0093);
      repeat (3) @(posedge clk);
      #1 rst = 0;
      wait_drain("after_reset");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {hw(4 * i + 2), hw(4 * i)};
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h00a0_0093;
      mem[8] = 32'h4505_0001;
      mem[16] = 32'h0513_0001;
      mem[17] = 32'h1234_0050;
      mem[64] = 32'h0001_ffff;
      mem[65] = 32'h0000_4505;
      test_reset;
      test_compressed;
      test_straddle;
      test_redirect_stale;
      test_backpressure;
      test_redirect_rvalid_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
